// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared types and constants for the fetch stage
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [15:0] PC_INC = 16'd2;
  localparam logic [15:0] NOP    = 16'h0000;

  // Instructions are halfword aligned; the low address bit is never honoured.
  function automatic logic [15:0] align_pc(input logic [15:0] addr);
    return {addr[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory request/ack bus
interface fetch_stage_if;

  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);

endinterface

// File: rtl/register_16b.sv
// rtl/register_16b.sv - 16-bit enabled register with synchronous reset value
module register_16b #(
  parameter logic [15:0] RST_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic [15:0] d_i,
  output logic [15:0] q_o
);

  logic [15:0] q_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= RST_VAL;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch with stall hold buffer and redirect drain
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [15:0]          redirect_pc,
  fetch_stage_if.master        imem,
  output logic [15:0]          inst_data,
  output logic [15:0]          pc,
  output logic                 ifid_write,
  output logic                 flush
);

  fetch_state_e state_q, state_d;

  logic [15:0] fetch_pc_q, fetch_pc_d;
  logic        fetch_pc_en;
  logic [15:0] hold_data_q, hold_pc_q;
  logic        hold_en;
  logic [15:0] target_q;
  logic        target_en;
  logic [15:0] redir_pc;

  assign redir_pc = align_pc(redirect_pc);

  register_16b #(.RST_VAL(RESET_PC)) u_fetch_pc (
    .clk(clk), .rst(rst), .en_i(fetch_pc_en), .d_i(fetch_pc_d), .q_o(fetch_pc_q)
  );

  register_16b #(.RST_VAL(16'h0000)) u_hold_data (
    .clk(clk), .rst(rst), .en_i(hold_en), .d_i(imem.imem_rdata), .q_o(hold_data_q)
  );

  register_16b #(.RST_VAL(16'h0000)) u_hold_pc (
    .clk(clk), .rst(rst), .en_i(hold_en), .d_i(fetch_pc_q), .q_o(hold_pc_q)
  );

  register_16b #(.RST_VAL(16'h0000)) u_target (
    .clk(clk), .rst(rst), .en_i(target_en), .d_i(redir_pc), .q_o(target_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Delivery must be combinational so a zero-wait ack reaches IF/ID in the same cycle.
  always_comb begin
    state_d       = state_q;
    fetch_pc_en   = 1'b0;
    fetch_pc_d    = fetch_pc_q;
    hold_en       = 1'b0;
    target_en     = 1'b0;
    imem.imem_req = 1'b0;
    ifid_write    = 1'b0;
    inst_data     = NOP;
    pc            = NOP;
    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          imem.imem_req = 1'b1;
          if (redirect) begin
            if (imem.imem_ack) begin
              fetch_pc_en = 1'b1;
              fetch_pc_d  = redir_pc;
            end else begin
              target_en = 1'b1;
              state_d   = ST_DRAIN;
            end
          end else if (imem.imem_ack) begin
            fetch_pc_en = 1'b1;
            fetch_pc_d  = fetch_pc_q + PC_INC;
            if (stall) begin
              hold_en = 1'b1;
              state_d = ST_HOLD;
            end else begin
              ifid_write = 1'b1;
              inst_data  = imem.imem_rdata;
              pc         = fetch_pc_q;
            end
          end
        end
        ST_HOLD: begin
          if (redirect) begin
            fetch_pc_en = 1'b1;
            fetch_pc_d  = redir_pc;
            state_d     = ST_FETCH;
          end else if (!stall) begin
            ifid_write = 1'b1;
            inst_data  = hold_data_q;
            pc         = hold_pc_q;
            state_d    = ST_FETCH;
          end
        end
        ST_DRAIN: begin
          // The stale request stays on the bus until acked; the newest redirect wins.
          imem.imem_req = 1'b1;
          target_en     = redirect;
          if (imem.imem_ack) begin
            fetch_pc_en = 1'b1;
            fetch_pc_d  = redirect ? redir_pc : target_q;
            state_d     = ST_FETCH;
          end
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  assign imem.imem_addr = fetch_pc_q;
  assign flush          = rst | redirect | (!ifid_write & !stall);

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] inst_data;
  logic [15:0] pc;
  logic        ifid_write;
  logic        flush;
  int          checks;
  int          errors;

  fetch_stage_if imem_bus ();

  fetch_stage #(.RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (imem_bus),
    .inst_data   (inst_data),
    .pc          (pc),
    .ifid_write  (ifid_write),
    .flush       (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Address is only meaningful while a request is being made.
  task automatic outs(input string tag, input logic req_e, input logic [15:0] addr_e,
                      input logic wr_e, input logic [15:0] inst_e, input logic [15:0] pc_e,
                      input logic flush_e);
    chk({tag, ".req"}, {15'd0, imem_bus.imem_req}, {15'd0, req_e});
    if (req_e) chk({tag, ".addr"}, imem_bus.imem_addr, addr_e);
    chk({tag, ".wr"}, {15'd0, ifid_write}, {15'd0, wr_e});
    chk({tag, ".inst"}, inst_data, inst_e);
    chk({tag, ".pc"}, pc, pc_e);
    chk({tag, ".flush"}, {15'd0, flush}, {15'd0, flush_e});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic st, input logic rd, input logic [15:0] rpc,
                     input logic ack, input logic [15:0] rdata);
    stall               = st;
    redirect            = rd;
    redirect_pc         = rpc;
    imem_bus.imem_ack   = ack;
    imem_bus.imem_rdata = rdata;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drv(0, 0, 16'h0000, 0, 16'h0000);
    cyc();
    outs("reset", 0, 16'h0000, 0, 16'h0000, 16'h0000, 1);
    rst = 1'b0;

    // zero-wait streaming
    drv(0, 0, 16'h0000, 1, 16'h1000); outs("z0", 1, 16'h0000, 1, 16'h1000, 16'h0000, 0); cyc();
    drv(0, 0, 16'h0000, 1, 16'h1002); outs("z1", 1, 16'h0002, 1, 16'h1002, 16'h0002, 0); cyc();
    drv(0, 0, 16'h0000, 1, 16'h1004); outs("z2", 1, 16'h0004, 1, 16'h1004, 16'h0004, 0); cyc();

    // redirect with ack, odd target aligned down to 0010, then 2-cycle late ack
    drv(0, 1, 16'h0011, 1, 16'hFFFF); outs("rd1", 1, 16'h0006, 0, 16'h0000, 16'h0000, 1); cyc();
    drv(0, 0, 16'h0000, 0, 16'h0000); outs("late0", 1, 16'h0010, 0, 16'h0000, 16'h0000, 1); cyc();
    drv(0, 0, 16'h0000, 0, 16'h0000); outs("late1", 1, 16'h0010, 0, 16'h0000, 16'h0000, 1); cyc();
    drv(0, 0, 16'h0000, 1, 16'hBEEF); outs("late2", 1, 16'h0010, 1, 16'hBEEF, 16'h0010, 0); cyc();

    // stall on ack at 0020 -> hold buffer, release delivers the buffered word
    drv(0, 1, 16'h0020, 1, 16'h1111); outs("rd2", 1, 16'h0012, 0, 16'h0000, 16'h0000, 1); cyc();
    drv(1, 0, 16'h0000, 1, 16'hA5A5); outs("hs0", 1, 16'h0020, 0, 16'h0000, 16'h0000, 0); cyc();
    drv(1, 0, 16'h0000, 0, 16'h0000); outs("hs1", 0, 16'h0000, 0, 16'h0000, 16'h0000, 0); cyc();
    drv(1, 0, 16'h0000, 0, 16'h0000); outs("hs2", 0, 16'h0000, 0, 16'h0000, 16'h0000, 0); cyc();
    drv(0, 0, 16'h0000, 0, 16'h0000); outs("hs3", 0, 16'h0000, 1, 16'hA5A5, 16'h0020, 0); cyc();

    // redirect to 0100 while 0040 is unacked -> drain
    drv(0, 1, 16'h0040, 1, 16'h2222); outs("rd3", 1, 16'h0022, 0, 16'h0000, 16'h0000, 1); cyc();
    drv(0, 1, 16'h0100, 0, 16'h0000); outs("dr0", 1, 16'h0040, 0, 16'h0000, 16'h0000, 1); cyc();
    drv(0, 0, 16'h0000, 0, 16'h0000); outs("dr1", 1, 16'h0040, 0, 16'h0000, 16'h0000, 1); cyc();
    drv(0, 0, 16'h0000, 1, 16'hDEAD); outs("dr2", 1, 16'h0040, 0, 16'h0000, 16'h0000, 1); cyc();

    // second redirect inside drain overwrites the target (0200 -> 0300)
    drv(0, 1, 16'h0200, 0, 16'h0000); outs("dr3", 1, 16'h0100, 0, 16'h0000, 16'h0000, 1); cyc();
    drv(0, 1, 16'h0301, 0, 16'h0000); outs("dr4", 1, 16'h0100, 0, 16'h0000, 16'h0000, 1); cyc();
    drv(0, 0, 16'h0000, 1, 16'h3333); outs("dr5", 1, 16'h0100, 0, 16'h0000, 16'h0000, 1); cyc();

    // stall without ack holds IF/ID; then redirect discards a held word
    drv(1, 0, 16'h0000, 0, 16'h0000); outs("st0", 1, 16'h0300, 0, 16'h0000, 16'h0000, 0); cyc();
    drv(1, 0, 16'h0000, 1, 16'h7777); outs("st1", 1, 16'h0300, 0, 16'h0000, 16'h0000, 0); cyc();
    drv(1, 1, 16'h0500, 0, 16'h0000); outs("hr0", 0, 16'h0000, 0, 16'h0000, 16'h0000, 1); cyc();

    // wrap-around at FFFE
    drv(0, 1, 16'hFFFE, 1, 16'h4444); outs("hr1", 1, 16'h0500, 0, 16'h0000, 16'h0000, 1); cyc();
    drv(0, 0, 16'h0000, 1, 16'h1234); outs("wrap0", 1, 16'hFFFE, 1, 16'h1234, 16'hFFFE, 0); cyc();
    drv(0, 0, 16'h0000, 1, 16'h5555); outs("wrap1", 1, 16'h0000, 1, 16'h5555, 16'h0000, 0); cyc();

    // reset in the middle of a drain restarts at RESET_PC with no delivery
    drv(0, 1, 16'h0700, 0, 16'h0000); outs("rdr", 1, 16'h0002, 0, 16'h0000, 16'h0000, 1); cyc();
    rst = 1'b1;
    drv(0, 0, 16'h0000, 1, 16'h9999); outs("rst1", 0, 16'h0000, 0, 16'h0000, 16'h0000, 1); cyc();
    rst = 1'b0;
    drv(0, 0, 16'h0000, 0, 16'h0000); outs("rst2", 1, 16'h0000, 0, 16'h0000, 16'h0000, 1); cyc();
    drv(0, 0, 16'h0000, 1, 16'h4321); outs("rst3", 1, 16'h0000, 1, 16'h4321, 16'h0000, 0); cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
